// File: rtl/imm_ext_pipe.sv
// LEGv8 immediate extractor/extender: decodes D/CB/B/I/IW formats, extends to DATA_W,
// and presents results through a 2-entry valid/ready output buffer with an illegal-encoding counter.

module imm_ext_dec #(
   parameter int DATA_W       = 64,
   parameter int SHIFT_BRANCH = 0
) (
   input  logic [31:0]       instr,
   output logic [DATA_W-1:0] imm,
   output logic [2:0]        fmt,
   output logic              illegal
);
   localparam logic [2:0] F_NONE = 3'd0, F_D = 3'd1, F_CB = 3'd2, F_B = 3'd3,
                          F_I = 3'd4, F_IW = 3'd5;

   logic [DATA_W-1:0] d_sx, cb_sx, b_sx, i_zx, iw_zx;
   logic              unused_rt;

   assign d_sx  = {{(DATA_W-9){instr[20]}}, instr[20:12]};
   assign cb_sx = {{(DATA_W-19){instr[23]}}, instr[23:5]};
   assign b_sx  = {{(DATA_W-26){instr[25]}}, instr[25:0]};
   assign i_zx  = {{(DATA_W-12){1'b0}}, instr[21:10]};
   assign iw_zx = {{(DATA_W-16){1'b0}}, instr[20:5]};
   assign unused_rt = ^instr[4:0];

   // First match wins; anything unmatched falls through to the illegal default.
   always_comb begin
      imm     = '0;
      fmt     = F_NONE;
      illegal = 1'b1;
      if (instr[31:21] == 11'b11111000010 || instr[31:21] == 11'b11111000000) begin
         imm = d_sx; fmt = F_D; illegal = 1'b0;
      end else if (instr[31:24] == 8'b10110100 || instr[31:24] == 8'b10110101) begin
         imm = (SHIFT_BRANCH != 0) ? (cb_sx << 2) : cb_sx; fmt = F_CB; illegal = 1'b0;
      end else if (instr[31:26] == 6'b000101) begin
         imm = (SHIFT_BRANCH != 0) ? (b_sx << 2) : b_sx; fmt = F_B; illegal = 1'b0;
      end else if (instr[31:22] == 10'b1001000100 || instr[31:22] == 10'b1101000100) begin
         imm = i_zx; fmt = F_I; illegal = 1'b0;
      end else if (instr[31:23] == 9'b110100101) begin
         // A 32-bit datapath cannot hold a MOVZ placed at hw=2/3.
         if (!((DATA_W == 32) && instr[22])) begin
            imm = iw_zx << {instr[22:21], 4'b0000}; fmt = F_IW; illegal = 1'b0;
         end
      end
   end
endmodule

module imm_ext_pipe #(
   parameter int DATA_W       = 64,
   parameter int SHIFT_BRANCH = 0,
   parameter int CNT_W        = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       instr,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] imm,
   output logic [2:0]        fmt,
   output logic              illegal,
   input  logic              clr_count,
   output logic [CNT_W-1:0]  illegal_count
);
   typedef struct packed {
      logic [DATA_W-1:0] imm;
      logic [2:0]        fmt;
      logic              ill;
   } ent_t;

   ent_t             dec, head_q, tail_q;
   logic [1:0]       occ_q;
   logic [CNT_W-1:0] cnt_q;
   logic             push, pop;

   imm_ext_dec #(.DATA_W(DATA_W), .SHIFT_BRANCH(SHIFT_BRANCH)) u_dec (
      .instr   (instr),
      .imm     (dec.imm),
      .fmt     (dec.fmt),
      .illegal (dec.ill)
   );

   assign in_ready  = (occ_q < 2'd2);
   assign out_valid = (occ_q != 2'd0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   // head_q always holds the oldest entry; tail_q is only meaningful at occupancy 2.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         occ_q  <= 2'd0;
         head_q <= '0;
         tail_q <= '0;
      end else begin
         case (occ_q)
            2'd0: if (push) begin
               head_q <= dec;
               occ_q  <= 2'd1;
            end
            2'd1: case ({push, pop})
               2'b10: begin tail_q <= dec; occ_q <= 2'd2; end
               2'b01: occ_q  <= 2'd0;
               2'b11: head_q <= dec;
               default: ;
            endcase
            default: if (pop) begin
               head_q <= tail_q;
               occ_q  <= 2'd1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         cnt_q <= '0;
      else if (clr_count)
         cnt_q <= '0;
      else if (push && dec.ill && (cnt_q != '1))
         cnt_q <= cnt_q + 1'b1;
   end

   assign imm           = head_q.imm;
   assign fmt           = head_q.fmt;
   assign illegal       = head_q.ill;
   assign illegal_count = cnt_q;
endmodule

// File: tb/tb_imm_ext_pipe.sv
// Bench for imm_ext_pipe: three parameterisations driven in lockstep, checked against an
// arithmetic decode model and an instruction-queue scoreboard.
module tb_imm_ext_pipe;
   logic        clk = 1'b0;
   logic        reset_n;
   logic        in_valid, out_ready, clr_count;
   logic [31:0] instr;

   logic        in_ready0, in_ready1, in_ready2;
   logic        out_valid0, out_valid1, out_valid2;
   logic [63:0] imm0, imm1;
   logic [31:0] imm2;
   logic [2:0]  fmt0, fmt1, fmt2;
   logic        ill0, ill1, ill2;
   logic [15:0] cnt0, cnt2;
   logic [2:0]  cnt1;

   always #5 clk = ~clk;

   imm_ext_pipe #(.DATA_W(64), .SHIFT_BRANCH(0), .CNT_W(16)) u0 (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready0), .instr(instr),
      .out_valid(out_valid0), .out_ready(out_ready), .imm(imm0), .fmt(fmt0), .illegal(ill0),
      .clr_count(clr_count), .illegal_count(cnt0));
   imm_ext_pipe #(.DATA_W(64), .SHIFT_BRANCH(1), .CNT_W(3)) u1 (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready1), .instr(instr),
      .out_valid(out_valid1), .out_ready(out_ready), .imm(imm1), .fmt(fmt1), .illegal(ill1),
      .clr_count(clr_count), .illegal_count(cnt1));
   imm_ext_pipe #(.DATA_W(32), .SHIFT_BRANCH(0), .CNT_W(16)) u2 (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready2), .instr(instr),
      .out_valid(out_valid2), .out_ready(out_ready), .imm(imm2), .fmt(fmt2), .illegal(ill2),
      .clr_count(clr_count), .illegal_count(cnt2));

   typedef struct {
      logic [63:0] imm;
      logic [2:0]  fmt;
      logic        ill;
   } ref_t;

   localparam int DWS  [3] = '{64, 64, 32};
   localparam int SBS  [3] = '{0, 1, 0};
   localparam int CMAX [3] = '{65535, 7, 65535};

   int          n_chk = 0, n_fail = 0, n_dut_pop = 0;
   logic [31:0] q[$];
   longint      cnt_m[3];

   // Reference decode: field values treated as integers, sign handled by subtraction.
   function automatic ref_t ref_dec(input logic [31:0] i, input int dw, input int sb);
      ref_t   r;
      longint v;
      logic [63:0] u;
      r.imm = '0; r.fmt = 3'd0; r.ill = 1'b1; v = 0;
      if (i[31:21] == 11'b11111000010 || i[31:21] == 11'b11111000000) begin
         v = longint'(i[20:12]); if (v >= 256) v -= 512; r.fmt = 3'd1; r.ill = 1'b0;
      end else if (i[31:24] == 8'hB4 || i[31:24] == 8'hB5) begin
         v = longint'(i[23:5]); if (v >= 262144) v -= 524288;
         if (sb != 0) v = v * 4;
         r.fmt = 3'd2; r.ill = 1'b0;
      end else if (i[31:26] == 6'b000101) begin
         v = longint'(i[25:0]); if (v >= 33554432) v -= 67108864;
         if (sb != 0) v = v * 4;
         r.fmt = 3'd3; r.ill = 1'b0;
      end else if (i[31:22] == 10'b1001000100 || i[31:22] == 10'b1101000100) begin
         v = longint'(i[21:10]); r.fmt = 3'd4; r.ill = 1'b0;
      end else if (i[31:23] == 9'b110100101) begin
         if (!(dw == 32 && i[22])) begin
            v = longint'(i[20:5]) * (longint'(1) << (16 * int'(i[22:21])));
            r.fmt = 3'd5; r.ill = 1'b0;
         end
      end
      u = v;
      r.imm = (dw == 32) ? {32'h0, u[31:0]} : u;
      return r;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_inst(input int k, input logic rdy, input logic vld, input logic [63:0] im,
                           input logic [2:0] f, input logic il, input logic [63:0] cnt);
      ref_t r;
      chk($sformatf("u%0d_in_ready", k), rdy, q.size() < 2);
      chk($sformatf("u%0d_out_valid", k), vld, q.size() != 0);
      chk($sformatf("u%0d_count", k), cnt, cnt_m[k]);
      if (q.size() != 0) begin
         r = ref_dec(q[0], DWS[k], SBS[k]);
         chk($sformatf("u%0d_imm(%h)", k, q[0]), im, r.imm);
         chk($sformatf("u%0d_fmt(%h)", k, q[0]), f, r.fmt);
         chk($sformatf("u%0d_illegal(%h)", k, q[0]), il, r.ill);
      end
   endtask

   task automatic check_state();
      chk_inst(0, in_ready0, out_valid0, imm0, fmt0, ill0, cnt0);
      chk_inst(1, in_ready1, out_valid1, imm1, fmt1, ill1, cnt1);
      chk_inst(2, in_ready2, out_valid2, imm2, fmt2, ill2, cnt2);
      if (out_valid0 && out_ready) n_dut_pop++;
   endtask

   // Called 1 time unit after a rising edge; drives, checks before the next edge, advances model.
   task automatic cycle(input logic iv, input logic [31:0] ins, input logic ordy, input logic clr);
      bit   psh, pp;
      ref_t r;
      in_valid = iv; instr = ins; out_ready = ordy; clr_count = clr;
      #2;
      check_state();
      psh = iv && (q.size() < 2);
      pp  = ordy && (q.size() != 0);
      @(posedge clk);
      if (pp) void'(q.pop_front());
      if (psh) q.push_back(ins);
      for (int k = 0; k < 3; k++) begin
         r = ref_dec(ins, DWS[k], SBS[k]);
         if (clr) cnt_m[k] = 0;
         else if (psh && r.ill && cnt_m[k] < CMAX[k]) cnt_m[k]++;
      end
      #1;
   endtask

   // Push into an empty buffer, check head constants one edge later, then pop.
   task automatic direct(input string tag, input logic [31:0] ins, input logic [63:0] e0,
                         input logic [63:0] e1, input logic [31:0] e2, input logic [2:0] f0,
                         input logic [2:0] f2, input logic il2);
      cycle(1'b1, ins, 1'b0, 1'b0);
      chk({tag, "_vld"}, out_valid0, 1'b1);
      chk({tag, "_imm64"}, imm0, e0);
      chk({tag, "_imm64sb"}, imm1, e1);
      chk({tag, "_imm32"}, imm2, e2);
      chk({tag, "_fmt"}, fmt0, f0);
      chk({tag, "_fmt32"}, fmt2, f2);
      chk({tag, "_ill32"}, ill2, il2);
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
   endtask

   function automatic logic [31:0] gen();
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 7))
         0: gen = {(r[31] ? 11'b11111000010 : 11'b11111000000), r[20:0]};
         1: gen = {7'b1011010, r[24:0]};
         2: gen = {6'b000101, r[25:0]};
         3: gen = {(r[31] ? 10'b1001000100 : 10'b1101000100), r[21:0]};
         4: gen = {9'b110100101, r[22:0]};
         default: gen = r;
      endcase
   endfunction

   initial begin
      logic [31:0] a, b, c;
      reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr_count = 1'b0; instr = '0;
      for (int k = 0; k < 3; k++) cnt_m[k] = 0;
      #3;
      chk("rst_out_valid", out_valid0, 1'b0);
      chk("rst_in_ready", in_ready0, 1'b1);
      chk("rst_imm", imm0, 64'h0);
      chk("rst_fmt", fmt0, 3'd0);
      chk("rst_illegal", ill0, 1'b0);
      chk("rst_count", cnt0, 64'h0);
      #9 reset_n = 1'b1;
      @(posedge clk); #1;
      cycle(1'b0, 32'h0, 1'b0, 1'b0);

      direct("ldur", {11'b11111000010, 9'h001, 12'h0}, 64'h1, 64'h1, 32'h1, 3'd1, 3'd1, 1'b0);
      direct("stur", {11'b11111000000, 9'h1FE, 12'h0}, 64'hFFFF_FFFF_FFFF_FFFE,
             64'hFFFF_FFFF_FFFF_FFFE, 32'hFFFF_FFFE, 3'd1, 3'd1, 1'b0);
      direct("cbz", {8'hB4, 19'h7FFFD, 5'h0}, 64'hFFFF_FFFF_FFFF_FFFD,
             64'hFFFF_FFFF_FFFF_FFF4, 32'hFFFF_FFFD, 3'd2, 3'd2, 1'b0);
      direct("b", {6'b000101, 26'h3}, 64'h3, 64'hC, 32'h3, 3'd3, 3'd3, 1'b0);
      direct("addi", {10'b1001000100, 12'hFFF, 10'h0}, 64'hFFF, 64'hFFF, 32'hFFF, 3'd4, 3'd4, 1'b0);
      direct("movz3", {9'b110100101, 2'd3, 16'hBEEF, 5'h0}, 64'hBEEF_0000_0000_0000,
             64'hBEEF_0000_0000_0000, 32'h0, 3'd5, 3'd0, 1'b1);
      direct("movz1", {9'b110100101, 2'd1, 16'h1234, 5'h0}, 64'h1234_0000,
             64'h1234_0000, 32'h1234_0000, 3'd5, 3'd5, 1'b0);

      // Illegal encodings and counter clear priority
      cycle(1'b0, 32'h0, 1'b1, 1'b1);
      cycle(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
      cycle(1'b1, 32'hC0C4_C014, 1'b1, 1'b0);
      chk("ill_count2", cnt0, 64'd2);
      chk("ill_head", ill0, 1'b1);
      chk("ill_head_imm", imm0, 64'h0);
      cycle(1'b1, 32'h1234_5678, 1'b1, 1'b1);
      chk("ill_clr_prio", cnt0, 64'd0);
      cycle(1'b0, 32'h0, 1'b1, 1'b0);

      // Backpressure: third offer is held until space opens
      a = gen(); b = gen(); c = gen();
      cycle(1'b1, a, 1'b0, 1'b0);
      cycle(1'b1, b, 1'b0, 1'b0);
      chk("bp_full", in_ready0, 1'b0);
      cycle(1'b1, c, 1'b0, 1'b0);
      cycle(1'b1, c, 1'b1, 1'b0);
      cycle(1'b1, c, 1'b1, 1'b0);
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
      chk("bp_drained", out_valid0, 1'b0);

      // Full-rate streaming
      n_dut_pop = 0;
      for (int i = 0; i < 16; i++) cycle(1'b1, gen(), 1'b1, 1'b0);
      chk("stream_rate", n_dut_pop, 64'd15);
      cycle(1'b0, 32'h0, 1'b1, 1'b0);

      // Random traffic
      for (int i = 0; i < 600; i++)
         cycle($urandom_range(0, 3) != 0, gen(), $urandom_range(0, 2) != 0,
               $urandom_range(0, 60) == 0);

      // Asynchronous reset with two entries buffered
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
      cycle(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
      cycle(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
      chk("pre_rst_full", in_ready0, 1'b0);
      chk("pre_rst_count", cnt0 != 16'h0, 1'b1);
      in_valid = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      chk("arst_out_valid", out_valid0, 1'b0);
      chk("arst_in_ready", in_ready0, 1'b1);
      chk("arst_count", cnt0, 64'h0);
      chk("arst_count_sb", cnt1, 64'h0);
      q.delete();
      for (int k = 0; k < 3; k++) cnt_m[k] = 0;
      #1 reset_n = 1'b1;
      @(posedge clk); #1;
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
      for (int i = 0; i < 8; i++) cycle(1'b1, gen(), 1'b1, 1'b0);
      cycle(1'b0, 32'h0, 1'b1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
